// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache-line port to a 4-beat 64-bit memory burst bus.
// Reads assemble beats into a line; writes serialise a captured line into beats.
module cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);
   localparam int                BEATS     = LINE_W / BURST_W;
   localparam int                CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST      = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(LINE_W / 8 - 1);

   typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   // Separate read and write buffers so line_o holds across intervening writebacks.
   logic [LINE_W-1:0] rd_line_q, rd_line_d;
   logic [LINE_W-1:0] wr_line_q, wr_line_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         rd_line_q <= '0;
         wr_line_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rd_line_q <= rd_line_d;
         wr_line_q <= wr_line_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rd_line_d = rd_line_q;
      wr_line_d = wr_line_q;
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      burst_o   = '0;
      unique case (state_q)
         IDLE: begin
            // Writeback takes priority over refill when both are requested.
            if (write_i) begin
               state_d   = WR_BURST;
               addr_d    = address_i & ~OFFS_MASK;
               wr_line_d = line_i;
               cnt_d     = '0;
            end else if (read_i) begin
               state_d = RD_BURST;
               addr_d  = address_i & ~OFFS_MASK;
               cnt_d   = '0;
            end
         end
         RD_BURST: begin
            read_o = 1'b1;
            if (resp_i) begin
               rd_line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST) state_d = RD_DONE;
            end
         end
         RD_DONE: begin
            resp_o  = 1'b1;
            state_d = IDLE;
         end
         WR_BURST: begin
            write_o = 1'b1;
            burst_o = wr_line_q[int'(cnt_q)*BURST_W +: BURST_W];
            if (resp_i) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST) state_d = WR_DONE;
            end
         end
         WR_DONE: begin
            resp_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign line_o    = rd_line_q;
   assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, stalled writes, priority, async reset,
// back-to-back transfers and held requests, with hand-computed expectations.
`timescale 1ns/1ps
module tb_cacheline_adaptor;
   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int ADDR_W  = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [LINE_W-1:0]  line_i = '0;
   logic [LINE_W-1:0]  line_o;
   logic [ADDR_W-1:0]  address_i = '0;
   logic               read_i = 1'b0;
   logic               write_i = 1'b0;
   logic               resp_o;
   logic [BURST_W-1:0] burst_i = '0;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i = 1'b0;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   int t0   = 0;
   int t1   = 0;

   // Write-with-stalls table: resp_i per cycle and the beat expected on burst_o.
   logic         wr_resp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [63:0]  wr_beat [7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
                                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD,
                                 64'hDDDD_DDDD_DDDD_DDDD};

   localparam logic [LINE_W-1:0] RD1_LINE =
      256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
   localparam logic [LINE_W-1:0] RST_LINE =
      256'hE3E3E3E3E3E3E3E3_E2E2E2E2E2E2E2E2_E1E1E1E1E1E1E1E1_E0E0E0E0E0E0E0E0;
   localparam logic [LINE_W-1:0] HOLD_LINE =
      256'hF3F3F3F3F3F3F3F3_F2F2F2F2F2F2F2F2_F1F1F1F1F1F1F1F1_F0F0F0F0F0F0F0F0;

   always #5 clk = ~clk;

   cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .line_i   (line_i),
      .line_o   (line_o),
      .address_i(address_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .resp_o   (resp_o),
      .burst_i  (burst_i),
      .burst_o  (burst_o),
      .address_o(address_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .resp_i   (resp_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic rd, input logic wr, input logic rsp);
      chk({tag, ".read_o"},  LINE_W'(read_o),  LINE_W'(rd));
      chk({tag, ".write_o"}, LINE_W'(write_o), LINE_W'(wr));
      chk({tag, ".resp_o"},  LINE_W'(resp_o),  LINE_W'(rsp));
   endtask

   // Feeds four unstalled read beats, checking the bus each cycle; leaves resp_i low.
   task automatic feed_read(input string tag, input logic [ADDR_W-1:0] exp_addr,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
      logic [63:0] beats [4];
      beats = '{b0, b1, b2, b3};
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("%s.beat%0d", tag, i), 1'b1, 1'b0, 1'b0);
         chk($sformatf("%s.addr%0d", tag, i), LINE_W'(address_o), LINE_W'(exp_addr));
         burst_i = beats[i];
         resp_i  = 1'b1;
         tick();
      end
      resp_i  = 1'b0;
      burst_i = '0;
   endtask

   always @(negedge clk) begin
      vecs++;
      assert (!(read_o && write_o)) else begin
         errs++;
         $error("FAIL overlap: observed read_o=%0b write_o=%0b expected not both 1", read_o, write_o);
      end
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset.line_o", line_o, '0);
      chk("reset.burst_o", LINE_W'(burst_o), '0);
      chk("reset.address_o", LINE_W'(address_o), '0);
      rst_n = 1'b1;
      tick();

      // Read, no stalls
      address_i = 32'h0000_1234;
      read_i    = 1'b1;
      tick();
      feed_read("rd1", 32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      chk_ctl("rd1.done", 1'b0, 1'b0, 1'b1);
      chk("rd1.line_o", line_o, RD1_LINE);
      read_i = 1'b0;
      tick();
      chk_ctl("rd1.idle", 1'b0, 1'b0, 1'b0);
      chk("rd1.line_hold", line_o, RD1_LINE);

      // Write with stalls; line_i/address_i scrambled after acceptance
      line_i    = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
      address_i = 32'h8000_003F;
      write_i   = 1'b1;
      tick();
      line_i    = '1;
      address_i = 32'h1234_5678;
      for (int k = 0; k < 7; k++) begin
         chk_ctl($sformatf("wr.c%0d", k + 1), 1'b0, 1'b1, 1'b0);
         chk($sformatf("wr.burst_o.c%0d", k + 1), LINE_W'(burst_o), LINE_W'(wr_beat[k]));
         chk($sformatf("wr.addr.c%0d", k + 1), LINE_W'(address_o), LINE_W'(32'h8000_0020));
         resp_i = wr_resp[k];
         tick();
      end
      resp_i = 1'b0;
      chk_ctl("wr.done", 1'b0, 1'b0, 1'b1);
      chk("wr.burst_o.done", LINE_W'(burst_o), '0);
      chk("wr.line_o_kept", line_o, RD1_LINE);
      write_i = 1'b0;
      tick();
      chk_ctl("wr.idle", 1'b0, 1'b0, 1'b0);

      // Simultaneous read and write: write wins
      line_i    = 256'h0303030303030303_0202020202020202_0101010101010101_0F0F0F0F0F0F0F0F;
      address_i = 32'h0000_0040;
      read_i    = 1'b1;
      write_i   = 1'b1;
      tick();
      chk("both.burst_o0", LINE_W'(burst_o), LINE_W'(64'h0F0F_0F0F_0F0F_0F0F));
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("both.c%0d", i + 1), 1'b0, 1'b1, 1'b0);
         resp_i = 1'b1;
         tick();
      end
      resp_i = 1'b0;
      chk_ctl("both.done", 1'b0, 1'b0, 1'b1);
      read_i  = 1'b0;
      write_i = 1'b0;
      tick();
      chk_ctl("both.idle1", 1'b0, 1'b0, 1'b0);
      tick();
      chk_ctl("both.idle2", 1'b0, 1'b0, 1'b0);
      chk("both.line_o_kept", line_o, RD1_LINE);

      // Asynchronous reset after the second read beat
      address_i = 32'h0000_0040;
      read_i    = 1'b1;
      tick();
      resp_i  = 1'b1;
      burst_i = 64'h9999_9999_9999_9999;
      tick();
      burst_i = 64'h8888_8888_8888_8888;
      tick();
      resp_i = 1'b0;
      read_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_ctl("arst", 1'b0, 1'b0, 1'b0);
      chk("arst.line_o", line_o, '0);
      chk("arst.address_o", LINE_W'(address_o), '0);
      chk("arst.burst_o", LINE_W'(burst_o), '0);
      tick();
      rst_n   = 1'b1;
      resp_i  = 1'b1;
      burst_i = 64'h7777_7777_7777_7777;
      tick();
      chk_ctl("arst.spur1", 1'b0, 1'b0, 1'b0);
      tick();
      chk_ctl("arst.spur2", 1'b0, 1'b0, 1'b0);
      chk("arst.spur_line", line_o, '0);
      resp_i    = 1'b0;
      address_i = 32'h0000_0100;
      read_i    = 1'b1;
      tick();
      feed_read("rd2", 32'h0000_0100, 64'hE0E0_E0E0_E0E0_E0E0, 64'hE1E1_E1E1_E1E1_E1E1,
                64'hE2E2_E2E2_E2E2_E2E2, 64'hE3E3_E3E3_E3E3_E3E3);
      chk_ctl("rd2.done", 1'b0, 1'b0, 1'b1);
      chk("rd2.line_o", line_o, RST_LINE);
      read_i = 1'b0;
      tick();

      // Back-to-back writeback then refill
      line_i    = 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888;
      address_i = 32'h0000_0300;
      write_i   = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_ctl($sformatf("b2b.wr%0d", i), 1'b0, 1'b1, 1'b0);
         resp_i = 1'b1;
         tick();
      end
      chk_ctl("b2b.wr_done", 1'b0, 1'b0, 1'b1);
      t0      = cyc;
      write_i = 1'b0;
      tick();
      chk_ctl("b2b.idle", 1'b0, 1'b0, 1'b0);
      resp_i = 1'b0;
      read_i = 1'b1;
      tick();
      feed_read("b2b.rd", 32'h0000_0300, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF1F1_F1F1_F1F1_F1F1,
                64'hF2F2_F2F2_F2F2_F2F2, 64'hF3F3_F3F3_F3F3_F3F3);
      chk_ctl("b2b.rd_done", 1'b0, 1'b0, 1'b1);
      t1 = cyc;
      chk("b2b.resp_gap", LINE_W'(t1 - t0), LINE_W'(6));
      chk("b2b.line_o", line_o, HOLD_LINE);
      read_i = 1'b0;
      tick();

      // Request held one cycle past resp_o starts a second transfer
      address_i = 32'h0000_0200;
      read_i    = 1'b1;
      tick();
      feed_read("hold1", 32'h0000_0200, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF1F1_F1F1_F1F1_F1F1,
                64'hF2F2_F2F2_F2F2_F2F2, 64'hF3F3_F3F3_F3F3_F3F3);
      chk_ctl("hold1.done", 1'b0, 1'b0, 1'b1);
      tick();
      chk_ctl("hold.idle", 1'b0, 1'b0, 1'b0);
      tick();
      read_i = 1'b0;
      feed_read("hold2", 32'h0000_0200, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF1F1_F1F1_F1F1_F1F1,
                64'hF2F2_F2F2_F2F2_F2F2, 64'hF3F3_F3F3_F3F3_F3F3);
      chk_ctl("hold2.done", 1'b0, 1'b0, 1'b1);
      chk("hold2.line_o", line_o, HOLD_LINE);
      tick();
      chk_ctl("hold2.idle", 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
